// File: rtl/amba3_axi_sram_slave_pkg.sv
// Shared types and helpers for the AXI3 SRAM slave.
package amba3_axi_sram_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/amba3_axi_sram_slave_if.sv
// AXI3 bus bundle (AW/W/B/AR/R) with master and slave views.
interface amba3_axi_sram_slave_if #(
    parameter int TXID_SIZE = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 128
);
    logic [TXID_SIZE-1:0]   awid;
    logic [ADDR_SIZE-1:0]   awaddr;
    logic [3:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;
    logic [TXID_SIZE-1:0]   wid;
    logic [DATA_SIZE-1:0]   wdata;
    logic [DATA_SIZE/8-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;
    logic [TXID_SIZE-1:0]   bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [TXID_SIZE-1:0]   arid;
    logic [ADDR_SIZE-1:0]   araddr;
    logic [3:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;
    logic [TXID_SIZE-1:0]   rid;
    logic [DATA_SIZE-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/amba3_axi_burst_addr_gen.sv
// Per-beat AXI3 address step, byte-lane mask and legality of the burst shape.
module amba3_axi_burst_addr_gen
    import amba3_axi_sram_slave_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 128
) (
    input  logic [ADDR_SIZE-1:0]   addr,
    input  logic [3:0]             len,
    input  logic [2:0]             size,
    input  logic [1:0]             burst,
    output logic [ADDR_SIZE-1:0]   next_addr,
    output logic [DATA_SIZE/8-1:0] lane_mask,
    output logic                   legal
);
    localparam int BB      = DATA_SIZE / 8;
    localparam int LOG2_BB = clog2(BB);

    logic [ADDR_SIZE-1:0] sb, aligned, incr, wsize, lower, lo, hi;

    always_comb begin
        sb      = ADDR_SIZE'(1) << size;
        aligned = addr & ~(sb - ADDR_SIZE'(1));
        incr    = aligned + sb;
        wsize   = (ADDR_SIZE'(len) + ADDR_SIZE'(1)) * sb;
        lower   = addr & ~(wsize - ADDR_SIZE'(1));
        legal   = (int'(size) <= LOG2_BB) && (burst != 2'b11) &&
                  !((burst == WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));

        next_addr = addr;
        if (burst == INCR)
            next_addr = incr;
        else if (burst == WRAP)
            next_addr = (incr == lower + wsize) ? lower : incr;

        // Data stays on its natural lanes: first byte up to end of the sized container.
        lo        = addr & ADDR_SIZE'(BB - 1);
        hi        = (incr - ADDR_SIZE'(1)) & ADDR_SIZE'(BB - 1);
        lane_mask = '0;
        for (int i = 0; i < BB; i++)
            lane_mask[i] = (ADDR_SIZE'(i) >= lo) && (ADDR_SIZE'(i) <= hi);
    end
endmodule

// File: rtl/amba3_axi_sram_slave.sv
// AXI3 slave fronting a byte-writable SRAM; independent write and read FSMs.
module amba3_axi_sram_slave
    import amba3_axi_sram_slave_pkg::*;
#(
    parameter int TXID_SIZE = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 128,
    parameter int MEM_DEPTH = 1024,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
    input logic                    aclk,
    input logic                    areset,
    amba3_axi_sram_slave_if.slave  s
);
    localparam int BB      = DATA_SIZE / 8;
    localparam int LOG2_BB = clog2(BB);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE-1:0] MEM_BYTES = ADDR_SIZE'(MEM_DEPTH * BB);

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2;

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
    logic [DATA_SIZE-1:0] mem_rd_q;

    logic [1:0]           w_state_q, w_state_d, r_state_q, r_state_d;
    logic [TXID_SIZE-1:0] aw_id_q, aw_id_d, ar_id_q, ar_id_d;
    logic [ADDR_SIZE-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [3:0]           aw_len_q, aw_len_d, ar_len_q, ar_len_d;
    logic [2:0]           aw_size_q, aw_size_d, ar_size_q, ar_size_d;
    logic [1:0]           aw_burst_q, aw_burst_d, ar_burst_q, ar_burst_d;
    logic [3:0]           w_beat_q, w_beat_d, r_beat_q, r_beat_d;
    logic                 w_err_q, w_err_d, r_err_q, r_err_d;

    logic [ADDR_SIZE-1:0] w_next, r_next, w_off, r_off;
    logic [BB-1:0]        w_lanes, r_lanes_unused, mem_we;
    logic [IDX_W-1:0]     w_idx, r_idx;
    logic                 w_legal, r_legal, w_in_range, r_in_range, w_last_beat, r_fetch;
    logic                 b_valid, r_valid;

    amba3_axi_burst_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) u_wgen (
        .addr(aw_addr_q), .len(aw_len_q), .size(aw_size_q), .burst(aw_burst_q),
        .next_addr(w_next), .lane_mask(w_lanes), .legal(w_legal)
    );

    amba3_axi_burst_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) u_rgen (
        .addr(ar_addr_q), .len(ar_len_q), .size(ar_size_q), .burst(ar_burst_q),
        .next_addr(r_next), .lane_mask(r_lanes_unused), .legal(r_legal)
    );

    always_comb begin
        w_state_d = w_state_q;  aw_id_d = aw_id_q;      aw_addr_d = aw_addr_q;
        aw_len_d  = aw_len_q;   aw_size_d = aw_size_q;  aw_burst_d = aw_burst_q;
        w_beat_d  = w_beat_q;   w_err_d = w_err_q;      mem_we = '0;
        w_off       = aw_addr_q - BASE_ADDR;
        w_in_range  = w_off < MEM_BYTES;
        w_idx       = IDX_W'(w_off >> LOG2_BB);
        w_last_beat = (w_beat_q == aw_len_q);
        case (w_state_q)
            W_IDLE: if (s.awvalid) begin
                aw_id_d = s.awid;     aw_addr_d = s.awaddr;   aw_len_d = s.awlen;
                aw_size_d = s.awsize; aw_burst_d = s.awburst;
                w_beat_d = '0;        w_err_d = 1'b0;         w_state_d = W_DATA;
            end
            W_DATA: if (s.wvalid) begin
                // Illegal bursts are drained beat by beat but never touch the array.
                if (w_legal && w_in_range) mem_we = s.wstrb & w_lanes;
                if (!w_legal || !w_in_range || (s.wlast != w_last_beat) || (s.wid != aw_id_q))
                    w_err_d = 1'b1;
                aw_addr_d = w_next;
                w_beat_d  = w_beat_q + 4'd1;
                if (w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: if (s.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;  ar_id_d = ar_id_q;      ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;   ar_size_d = ar_size_q;  ar_burst_d = ar_burst_q;
        r_beat_d  = r_beat_q;   r_err_d = r_err_q;      r_fetch = 1'b0;
        r_off      = ar_addr_q - BASE_ADDR;
        r_in_range = r_off < MEM_BYTES;
        r_idx      = IDX_W'(r_off >> LOG2_BB);
        case (r_state_q)
            R_IDLE: if (s.arvalid) begin
                ar_id_d = s.arid;     ar_addr_d = s.araddr;   ar_len_d = s.arlen;
                ar_size_d = s.arsize; ar_burst_d = s.arburst;
                r_beat_d = '0;        r_state_d = R_FETCH;
            end
            R_FETCH: begin
                r_fetch   = 1'b1;
                r_err_d   = !(r_legal && r_in_range);
                r_state_d = R_DATA;
            end
            R_DATA: if (s.rready) begin
                if (r_beat_q == ar_len_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_beat_d  = r_beat_q + 4'd1;
                    ar_addr_d = r_next;
                    r_state_d = R_FETCH;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE; aw_id_q <= '0; aw_addr_q <= '0; aw_len_q <= '0;
            aw_size_q <= '0; aw_burst_q <= '0; w_beat_q <= '0; w_err_q <= 1'b0;
            r_state_q <= R_IDLE; ar_id_q <= '0; ar_addr_q <= '0; ar_len_q <= '0;
            ar_size_q <= '0; ar_burst_q <= '0; r_beat_q <= '0; r_err_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d; aw_id_q <= aw_id_d; aw_addr_q <= aw_addr_d;
            aw_len_q <= aw_len_d; aw_size_q <= aw_size_d; aw_burst_q <= aw_burst_d;
            w_beat_q <= w_beat_d; w_err_q <= w_err_d;
            r_state_q <= r_state_d; ar_id_q <= ar_id_d; ar_addr_q <= ar_addr_d;
            ar_len_q <= ar_len_d; ar_size_q <= ar_size_d; ar_burst_q <= ar_burst_d;
            r_beat_q <= r_beat_d; r_err_q <= r_err_d;
        end
    end

    // Non-blocking read and write in one block gives read-before-write on a collision.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < BB; i++)
            if (mem_we[i] && !areset) mem[w_idx][i*8 +: 8] <= s.wdata[i*8 +: 8];
        if (r_fetch) mem_rd_q <= mem[r_idx];
    end

    assign b_valid   = (w_state_q == W_RESP);
    assign r_valid   = (r_state_q == R_DATA);
    assign s.awready = (w_state_q == W_IDLE) && !areset;
    assign s.wready  = (w_state_q == W_DATA);
    assign s.bvalid  = b_valid;
    assign s.bid     = b_valid ? aw_id_q : '0;
    assign s.bresp   = (b_valid && w_err_q) ? SLVERR : OKAY;
    assign s.arready = (r_state_q == R_IDLE) && !areset;
    assign s.rvalid  = r_valid;
    assign s.rid     = r_valid ? ar_id_q : '0;
    assign s.rdata   = (r_valid && !r_err_q) ? mem_rd_q : '0;
    assign s.rresp   = (r_valid && r_err_q) ? SLVERR : OKAY;
    assign s.rlast   = r_valid && (r_beat_q == ar_len_q);
endmodule

// File: tb/tb_amba3_axi_sram_slave.sv
// Directed bench for the AXI3 SRAM slave: bursts, lane masks, errors, stalls, reset.
module tb_amba3_axi_sram_slave;
    import amba3_axi_sram_slave_pkg::*;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [127:0] wd   [16];
    logic [15:0]  ws   [16];
    logic [127:0] rexp [16];
    logic [7:0]   t1b  [5];

    localparam logic [127:0] W100A = 128'hEEEEEEEEEEEEEEEEEEEEEE3931231507;
    localparam logic [127:0] W100B = 128'hEEEEEEEEEEEEEEEEEED3EE3931231507;
    localparam logic [127:0] W200  = 128'hA1A1A1A1A1A1A1A1A0A0A0A0A0A0A0EE;
    localparam logic [127:0] W210A = 128'hEEEEEEEEEEEEEEEEA2A2A2A2A2A2A2A2;
    localparam logic [127:0] W210B = 128'hB2B2B1B1B0B0B3B3A2A2A2A2A2A2A2A2;

    amba3_axi_sram_slave_if #(.TXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(128)) bus ();

    amba3_axi_sram_slave #(
        .TXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(128), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)
    ) dut (
        .aclk(aclk), .areset(areset), .s(bus)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit hs; int n;
        hs = 0; n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        do begin @(negedge aclk); hs = bus.awready; @(posedge aclk); #1; n++; end
        while (!hs && n < 50);
        bus.awvalid = 1'b0;
        chk("aw_hs", hs, 1);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit hs; int n;
        hs = 0; n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        do begin @(negedge aclk); hs = bus.arready; @(posedge aclk); #1; n++; end
        while (!hs && n < 50);
        bus.arvalid = 1'b0;
        chk("ar_hs", hs, 1);
    endtask

    task automatic w_beat(input logic [127:0] d, input logic [15:0] st, input logic last,
                          input logic [3:0] id);
        bit hs; int n;
        hs = 0; n = 0;
        bus.wdata = d; bus.wstrb = st; bus.wlast = last; bus.wid = id; bus.wvalid = 1'b1;
        do begin @(negedge aclk); hs = bus.wready; @(posedge aclk); #1; n++; end
        while (!hs && n < 50);
        bus.wvalid = 1'b0;
        chk("w_hs", hs, 1);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int early,
                               input logic [3:0] wid, input logic [1:0] exp_resp, input string tag);
        bit hs; int n; logic [3:0] bid; logic [1:0] bresp;
        hs = 0; n = 0; bid = '0; bresp = '0;
        aw_send(id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++)
            w_beat(wd[b], ws[b], (early >= 0) ? (b == early) : (b == int'(len)), wid);
        bus.bready = 1'b1;
        do begin
            @(negedge aclk); hs = bus.bvalid; bid = bus.bid; bresp = bus.bresp;
            @(posedge aclk); #1; n++;
        end while (!hs && n < 50);
        bus.bready = 1'b0;
        chk({tag, "_bvalid"}, hs, 1);
        chk({tag, "_bid"}, bid, id);
        chk({tag, "_bresp"}, bresp, exp_resp);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int stall_beat,
                              input logic [1:0] exp_resp, input string tag);
        ar_send(id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            int n; bit got; logic [127:0] d0; logic l0;
            n = 0; got = 0;
            while (!got && n < 20) begin
                @(negedge aclk); got = bus.rvalid;
                if (!got) begin @(posedge aclk); #1; n++; end
            end
            chk({tag, "_lat"}, n, 1);
            if (!got) break;
            if (b == stall_beat) begin
                d0 = bus.rdata; l0 = bus.rlast;
                repeat (5) @(posedge aclk);
                @(negedge aclk);
                chk({tag, "_stall_vld"}, bus.rvalid, 1);
                chk({tag, "_stall_data"}, bus.rdata, d0);
                chk({tag, "_stall_last"}, bus.rlast, l0);
            end
            chk({tag, "_rid"}, bus.rid, id);
            chk({tag, "_rdata"}, bus.rdata, rexp[b]);
            chk({tag, "_rresp"}, bus.rresp, exp_resp);
            chk({tag, "_rlast"}, bus.rlast, b == int'(len));
            bus.rready = 1'b1;
            @(posedge aclk); #1;
            bus.rready = 1'b0;
        end
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 16'hFFFF; rexp[i] = '0; end
        t1b = '{8'h07, 8'h15, 8'h23, 8'h31, 8'h39};

        repeat (3) @(posedge aclk); #1;
        chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 0);
        chk("rst_valid", {bus.bvalid, bus.rvalid, bus.rlast}, 0);
        chk("rst_b", {bus.bid, bus.bresp}, 0);
        chk("rst_r", {bus.rid, bus.rresp}, 0);
        chk("rst_rdata", bus.rdata, 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("idle_ready", {bus.awready, bus.arready, bus.wready}, 3'b110);

        // known background in words 0x100, 0x200, 0x210
        wd[0] = {16{8'hEE}}; wd[1] = {16{8'hEE}};
        write_burst(4'd0, 32'h200, 4'd1, 3'd4, INCR, -1, 4'd0, OKAY, "pre200");
        write_burst(4'd0, 32'h100, 4'd0, 3'd4, INCR, -1, 4'd0, OKAY, "pre100");

        // INCR byte burst: only the addressed lane of each beat may be written
        for (int b = 0; b < 5; b++) begin
            wd[b] = {16{8'hAA}}; wd[b][8*b +: 8] = t1b[b]; rexp[b] = W100A;
        end
        write_burst(4'd1, 32'h100, 4'd4, 3'd0, INCR, -1, 4'd1, OKAY, "t1_w");
        read_burst(4'd1, 32'h100, 4'd4, 3'd0, INCR, -1, OKAY, "t1_r");

        // unaligned INCR doubleword burst
        wd[0] = {16{8'hA0}}; wd[1] = {16{8'hA1}}; wd[2] = {16{8'hA2}};
        write_burst(4'd2, 32'h201, 4'd2, 3'd3, INCR, -1, 4'd2, OKAY, "t2_w");
        rexp[0] = W200; rexp[1] = W200; rexp[2] = W210A;
        read_burst(4'd2, 32'h201, 4'd2, 3'd3, INCR, -1, OKAY, "t2_r");

        // WRAP halfword x4: 0x21A,0x21C,0x21E then wraps to 0x218
        for (int b = 0; b < 4; b++) begin wd[b] = {16{8'hB0 + 8'(b)}}; rexp[b] = W210B; end
        write_burst(4'd3, 32'h21A, 4'd3, 3'd1, WRAP, -1, 4'd3, OKAY, "t3_w");
        read_burst(4'd3, 32'h21A, 4'd3, 3'd1, WRAP, -1, OKAY, "t3_r");
        for (int b = 0; b < 3; b++) wd[b] = {16{8'hC0}};
        write_burst(4'd3, 32'h210, 4'd2, 3'd1, WRAP, -1, 4'd3, SLVERR, "t3_badwrap");
        rexp[0] = W210B;
        read_burst(4'd3, 32'h210, 4'd0, 3'd4, INCR, -1, OKAY, "t3_nochange");
        for (int b = 0; b < 3; b++) rexp[b] = '0;
        read_burst(4'd3, 32'h210, 4'd2, 3'd1, WRAP, -1, SLVERR, "t3_badwrap_r");

        // FIXED byte burst: last beat wins on lane 6
        for (int b = 0; b < 4; b++) begin wd[b] = {16{8'hD0 + 8'(b)}}; rexp[b] = W100B; end
        write_burst(4'd4, 32'h106, 4'd3, 3'd0, FIXED, -1, 4'd4, OKAY, "t4_w");
        read_burst(4'd4, 32'h106, 4'd3, 3'd0, FIXED, -1, OKAY, "t4_r");

        // range edges and protocol errors
        wd[0] = {16{8'h5A}}; rexp[0] = {16{8'h5A}};
        write_burst(4'd8, 32'h3FF0, 4'd0, 3'd4, INCR, -1, 4'd8, OKAY, "t5_top_w");
        read_burst(4'd8, 32'h3FF0, 4'd0, 3'd4, INCR, -1, OKAY, "t5_top_r");
        write_burst(4'd5, 32'h4000, 4'd1, 3'd4, INCR, -1, 4'd5, SLVERR, "t5_oor_w");
        rexp[0] = '0; rexp[1] = '0;
        read_burst(4'd5, 32'h4000, 4'd1, 3'd4, INCR, -1, SLVERR, "t5_oor_r");
        write_burst(4'd6, 32'h120, 4'd2, 3'd4, INCR, 0, 4'd6, SLVERR, "t5_early");
        write_burst(4'd7, 32'h120, 4'd0, 3'd4, INCR, -1, 4'd8, SLVERR, "t5_wid");
        write_burst(4'd7, 32'h130, 4'd0, 3'd5, INCR, -1, 4'd7, SLVERR, "t5_size");
        write_burst(4'd7, 32'h130, 4'd0, 3'd2, 2'b11, -1, 4'd7, SLVERR, "t5_burst");

        // stalled read concurrent with a write burst
        for (int b = 0; b < 4; b++) begin wd[b] = {16{8'hF0 + 8'(b)}}; rexp[b] = W200; end
        fork
            write_burst(4'd9, 32'h300, 4'd3, 3'd4, INCR, -1, 4'd9, OKAY, "t6_w");
            read_burst(4'd10, 32'h200, 4'd3, 3'd4, FIXED, 1, OKAY, "t6_r");
        join
        for (int b = 0; b < 4; b++) rexp[b] = {16{8'hF0 + 8'(b)}};
        read_burst(4'd9, 32'h300, 4'd3, 3'd4, INCR, -1, OKAY, "t6_rb");

        // reset in the middle of both bursts
        ar_send(4'd11, 32'h200, 4'd3, 3'd4, FIXED);
        aw_send(4'd12, 32'h300, 4'd3, 3'd4, INCR);
        w_beat({16{8'h77}}, 16'hFFFF, 1'b0, 4'd12);
        chk("t7_pre_rvalid", bus.rvalid, 1);
        areset = 1'b1;
        @(posedge aclk); #1;
        chk("t7_rst_valid", {bus.bvalid, bus.rvalid, bus.wready}, 0);
        chk("t7_rst_ready", {bus.awready, bus.arready}, 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("t7_post_ready", {bus.awready, bus.arready}, 2'b11);
        chk("t7_post_valid", {bus.bvalid, bus.rvalid}, 0);
        rexp[0] = {16{8'h77}}; rexp[1] = {16{8'hF1}};
        read_burst(4'd13, 32'h300, 4'd1, 3'd4, INCR, -1, OKAY, "t7_rb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
